pupil_tracker: RTL

PUPIL_TRACKER -- requirements
Module: pupil_tracker

---
 rtl/pupil_pkg.sv | 27 ++
 rtl/pupil_run_finder.sv | 65 ++++++
 rtl/pupil_tracker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pupil_pkg.sv
// Shared types and defaults for the pupil tracker: FSM state encoding,
// default parameter values and the reported-result record.
package pupil_pkg;

    localparam int DEF_PIX_W     = 8;
    localparam int DEF_LINE_W    = 112;
    localparam int DEF_NUM_LINES = 112;
    localparam int DEF_COORD_W   = 8;

    // Result fields are sized for the widest supported COORD_W and sliced at the top.
    localparam int MAX_COORD_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN      = 2'd1,
        ST_LINE_DONE = 2'd2,
        ST_REPORT    = 2'd3
    } pupil_state_t;

    typedef struct packed {
        logic [MAX_COORD_W-1:0] x;
        logic [MAX_COORD_W-1:0] y;
        logic [MAX_COORD_W-1:0] width;
        logic                   found;
    } pupil_result_t;

endpackage

// File: rtl/pupil_run_finder.sv
// Per-line dark-run detector: finds the first falling edge (run begin) and
// the first following rising edge (run end) along one line of pixels.
module pupil_run_finder
    import pupil_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               pix_en,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic [PIX_W-1:0]   threshold,
    output logic [COORD_W-1:0] run_begin,
    output logic [COORD_W-1:0] run_end,
    output logic [COORD_W-1:0] run_width,
    output logic               closed
);

    logic [COORD_W-1:0] idx;
    logic [PIX_W-1:0]   prev;
    logic               has_begin;
    logic               in_range;
    logic               falls;
    logic               rises;

    assign in_range  = (idx < COORD_W'(LINE_W));
    assign falls     = (prev > pix_data) && ((prev - pix_data) > threshold);
    assign rises     = (pix_data > prev) && ((pix_data - prev) > threshold);
    assign run_width = run_end - run_begin + COORD_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            prev      <= '0;
            has_begin <= 1'b0;
            closed    <= 1'b0;
            run_begin <= '0;
            run_end   <= '0;
        end else if (clear) begin
            idx       <= '0;
            prev      <= '0;
            has_begin <= 1'b0;
            closed    <= 1'b0;
            run_begin <= '0;
            run_end   <= '0;
        end else if (pix_en && in_range) begin
            idx  <= idx + COORD_W'(1);
            prev <= pix_data;
            // Pixel 0 has no predecessor; only the first run per line counts.
            if (idx != '0) begin
                if (!has_begin && falls) begin
                    has_begin <= 1'b1;
                    run_begin <= idx;
                end else if (has_begin && !closed && rises) begin
                    closed  <= 1'b1;
                    run_end <= idx - COORD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pupil_tracker.sv
// Pupil tracker top: frame FSM, line counter, widest-run tracking and result
// outputs. Optional early frame stop is enabled by PUPIL_TRACKER_EARLY_STOP_EN.
module pupil_tracker
    import pupil_pkg::*;
#(
    parameter int PIX_W     = DEF_PIX_W,
    parameter int LINE_W    = DEF_LINE_W,
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int COORD_W   = DEF_COORD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic               line_end,
    input  logic [PIX_W-1:0]   threshold,
    output logic [COORD_W-1:0] pupil_x,
    output logic [COORD_W-1:0] pupil_y,
    output logic [COORD_W-1:0] pupil_width,
    output logic               pupil_valid,
    output logic               pupil_found,
    output logic               busy,
    output logic               overrun,
    output pupil_state_t       fsm_state
);

    // Pixel stream: a pixel is consumed on each clock with pix_valid high
    // while scanning; there is no backpressure, and line_end marks the last
    // pixel of a line (that pixel is consumed before the line is closed).

    pupil_state_t       state;
    pupil_state_t       state_nxt;
    pupil_result_t      res_q;
    logic [PIX_W-1:0]   thresh_q;
    logic [COORD_W-1:0] line_cnt;
    logic [COORD_W-1:0] line_cnt_inc;
    logic [COORD_W-1:0] max_w;
    logic [COORD_W-1:0] best_x;
    logic [COORD_W-1:0] best_y;
    logic               found_q;
    logic               overrun_q;
    logic               drain_q;
    logic               valid_q;

    logic               pix_en;
    logic               rf_clear;
    logic [COORD_W-1:0] rf_begin;
    logic [COORD_W-1:0] rf_end;
    logic [COORD_W-1:0] rf_width;
    logic               rf_closed;
    logic [COORD_W:0]   centre_sum;
    logic [COORD_W-1:0] centre;
    logic               record;
    logic               last_line;
    logic               stop_now;
    logic               to_report;
    logic               proto_err;
    logic               found_nxt;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic [COORD_W-1:0] w_nxt;

    pupil_run_finder #(
        .PIX_W   (PIX_W),
        .LINE_W  (LINE_W),
        .COORD_W (COORD_W)
    ) u_run_finder (
        .clock     (clock),
        .reset     (reset),
        .clear     (rf_clear),
        .pix_en    (pix_en),
        .pix_data  (pix_data),
        .threshold (thresh_q),
        .run_begin (rf_begin),
        .run_end   (rf_end),
        .run_width (rf_width),
        .closed    (rf_closed)
    );

    assign pix_en       = (state == ST_SCAN) && pix_valid && !frame_start;
    // The run finder is wiped after each evaluated line and outside scanning.
    assign rf_clear     = frame_start || (state != ST_SCAN);
    assign centre_sum   = {1'b0, rf_begin} + {1'b0, rf_end};
    assign centre       = centre_sum[COORD_W:1];
    assign line_cnt_inc = line_cnt + COORD_W'(1);
    assign last_line    = (line_cnt_inc == COORD_W'(NUM_LINES));
    assign record       = (state == ST_LINE_DONE) && rf_closed && (rf_width > max_w);

`ifdef PUPIL_TRACKER_EARLY_STOP_EN
    // A narrower closed run after the widest one means the pupil is behind us.
    assign stop_now = (state == ST_LINE_DONE) && found_q && rf_closed && (rf_width < max_w);
`else
    assign stop_now = 1'b0;
`endif

    assign to_report = (state == ST_LINE_DONE) && !frame_start && (last_line || stop_now);
    assign found_nxt = found_q || record;
    assign x_nxt     = record ? centre   : best_x;
    assign y_nxt     = record ? line_cnt : best_y;
    assign w_nxt     = record ? rf_width : max_w;

    assign proto_err = !drain_q &&
                       ((pix_valid && ((state == ST_LINE_DONE) || (state == ST_REPORT))) ||
                        ((pix_valid || line_end) && (state == ST_IDLE)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = ST_SCAN;
        end else begin
            case (state)
                ST_IDLE:      state_nxt = ST_IDLE;
                ST_SCAN:      if (line_end) state_nxt = ST_LINE_DONE;
                ST_LINE_DONE: state_nxt = (last_line || stop_now) ? ST_REPORT : ST_SCAN;
                ST_REPORT:    state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thresh_q  <= '0;
            line_cnt  <= '0;
            max_w     <= '0;
            best_x    <= '0;
            best_y    <= '0;
            found_q   <= 1'b0;
            overrun_q <= 1'b0;
            drain_q   <= 1'b0;
            valid_q   <= 1'b0;
            res_q     <= '0;
        end else if (frame_start) begin
            thresh_q  <= threshold;
            line_cnt  <= '0;
            max_w     <= '0;
            best_x    <= '0;
            best_y    <= '0;
            found_q   <= 1'b0;
            overrun_q <= 1'b0;
            drain_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= to_report;
            if (proto_err) begin
                overrun_q <= 1'b1;
            end
            if (state == ST_LINE_DONE) begin
                line_cnt <= line_cnt_inc;
                // Strict compare keeps the earlier line on a width tie.
                if (record) begin
                    max_w   <= rf_width;
                    best_x  <= centre;
                    best_y  <= line_cnt;
                    found_q <= 1'b1;
                end
            end
            if (to_report) begin
                res_q.found <= found_nxt;
                if (found_nxt) begin
                    res_q.x     <= MAX_COORD_W'(x_nxt);
                    res_q.y     <= MAX_COORD_W'(y_nxt);
                    res_q.width <= MAX_COORD_W'(w_nxt);
                end
                if (stop_now) begin
                    drain_q <= 1'b1;
                end
            end
        end
    end

    generate
        if (COORD_W < MAX_COORD_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^{res_q.x[MAX_COORD_W-1:COORD_W],
                                  res_q.y[MAX_COORD_W-1:COORD_W],
                                  res_q.width[MAX_COORD_W-1:COORD_W]};
        end
    endgenerate

    assign pupil_x     = res_q.x[COORD_W-1:0];
    assign pupil_y     = res_q.y[COORD_W-1:0];
    assign pupil_width = res_q.width[COORD_W-1:0];
    assign pupil_found = res_q.found;
    assign pupil_valid = valid_q;
    assign busy        = (state != ST_IDLE);
    assign overrun     = overrun_q;
    assign fsm_state   = state;

endmodule
